// File: rtl/sequenciador_banco_pkg.sv
// Shared types for the register-bank access sequencer.
// Holds the FSM state enum, the default widths and the latched request record.
// Imported by the sequencer top; no logic lives here.
package sequenciador_banco_pkg;

    localparam int BITS_PALAVRA = 32;
    localparam int BITS_END     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEITURA,
        ST_OPERANDOS,
        ST_RESULTADO,
        ST_ESCRITA
    } estado_t;

    typedef struct packed {
        logic [BITS_END-1:0] src_a;
        logic [BITS_END-1:0] src_b;
        logic [BITS_END-1:0] dest;
        logic                escreve;
    } requisicao_t;

endpackage

// File: rtl/sequenciador_banco.sv
// Register-bank access sequencer: reads two operands, hands them to the ALU, writes the result back.
// Latency: operands valid 1 cycle after accept; min period 3 cycles (read-only) / 5 cycles (write-back).
// Backpressure: op_ready and res_valid may stall OPERANDOS / RESULTADO indefinitely; one request in flight.
module sequenciador_banco
    import sequenciador_banco_pkg::*;
#(
    parameter int bits_palavra = BITS_PALAVRA,
    parameter int bits_end     = BITS_END
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [bits_end-1:0]     i_req_src_a,
    input  logic [bits_end-1:0]     i_req_src_b,
    input  logic [bits_end-1:0]     i_req_dest,
    input  logic                    i_req_escreve,
    output logic                    o_op_valid,
    input  logic                    i_op_ready,
    output logic [bits_palavra-1:0] o_op_a,
    output logic [bits_palavra-1:0] o_op_b,
    input  logic                    i_res_valid,
    output logic                    o_res_ready,
    input  logic [bits_palavra-1:0] i_res_dado,
    output logic                    o_rf_habilita,
    output logic [bits_end-1:0]     o_rf_in_out_a,
    output logic [bits_end-1:0]     o_rf_out_b,
    output logic [bits_palavra-1:0] o_rf_e,
    input  logic [bits_palavra-1:0] i_rf_a,
    input  logic [bits_palavra-1:0] i_rf_b,
    output logic                    o_ocupado
);

    estado_t                 r_estado;
    requisicao_t             r_req;
    logic                    r_req_ready;
    logic                    r_op_valid;
    logic                    r_res_ready;
    logic                    r_rf_habilita;
    logic                    r_ocupado;
    logic [bits_palavra-1:0] r_op_a;
    logic [bits_palavra-1:0] r_op_b;
    logic [bits_palavra-1:0] r_rf_e;
    logic [bits_end-1:0]     r_rf_in_out_a;
    logic [bits_end-1:0]     r_rf_out_b;

    requisicao_t             w_req;

    assign w_req = {i_req_src_a, i_req_src_b, i_req_dest, i_req_escreve};

    // Sequencer FSM; every handshake flag is a register updated together with the state.
    // The bank refreshes its outputs on the falling edge, so addresses are driven from the
    // accept edge and the operands are sampled on the rising edge that leaves LEITURA.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado      <= ST_IDLE;
            r_req         <= '0;
            r_req_ready   <= 1'b1;
            r_op_valid    <= 1'b0;
            r_res_ready   <= 1'b0;
            r_rf_habilita <= 1'b0;
            r_ocupado     <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rf_e        <= '0;
            r_rf_in_out_a <= '0;
            r_rf_out_b    <= '0;
        end else begin
            case (r_estado)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_req         <= w_req;
                        r_rf_in_out_a <= w_req.src_a;
                        r_rf_out_b    <= w_req.src_b;
                        r_req_ready   <= 1'b0;
                        r_ocupado     <= 1'b1;
                        r_estado      <= ST_LEITURA;
                    end
                end
                ST_LEITURA: begin
                    // Keep the read addresses on the latched sources while the bank answers.
                    r_rf_in_out_a <= r_req.src_a;
                    r_rf_out_b    <= r_req.src_b;
                    r_op_a        <= i_rf_a;
                    r_op_b        <= i_rf_b;
                    r_op_valid    <= 1'b1;
                    r_estado      <= ST_OPERANDOS;
                end
                ST_OPERANDOS: begin
                    if (i_op_ready) begin
                        r_op_valid <= 1'b0;
                        if (r_req.escreve) begin
                            r_res_ready <= 1'b1;
                            r_estado    <= ST_RESULTADO;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_ocupado   <= 1'b0;
                            r_estado    <= ST_IDLE;
                        end
                    end
                end
                ST_RESULTADO: begin
                    if (i_res_valid) begin
                        r_rf_e        <= i_res_dado;
                        r_rf_in_out_a <= r_req.dest;
                        r_rf_habilita <= 1'b1;
                        r_res_ready   <= 1'b0;
                        r_estado      <= ST_ESCRITA;
                    end
                end
                ST_ESCRITA: begin
                    // Single write-back cycle; the bank commits it on the falling edge.
                    r_rf_habilita <= 1'b0;
                    r_req_ready   <= 1'b1;
                    r_ocupado     <= 1'b0;
                    r_estado      <= ST_IDLE;
                end
                default: begin
                    r_op_valid    <= 1'b0;
                    r_res_ready   <= 1'b0;
                    r_rf_habilita <= 1'b0;
                    r_req_ready   <= 1'b1;
                    r_ocupado     <= 1'b0;
                    r_estado      <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_op_valid    = r_op_valid;
    assign o_res_ready   = r_res_ready;
    assign o_rf_habilita = r_rf_habilita;
    assign o_ocupado     = r_ocupado;
    assign o_op_a        = r_op_a;
    assign o_op_b        = r_op_b;
    assign o_rf_e        = r_rf_e;
    assign o_rf_in_out_a = r_rf_in_out_a;
    assign o_rf_out_b    = r_rf_out_b;

endmodule

// File: tb/tb_sequenciador_banco.sv
// Bench for sequenciador_banco: falling-edge register bank, reference register file and scoreboard.
// Operand and write-back expectations are queued at issue time and checked by an independent monitor.
// Directed hazard/stall/reset scenarios are followed by randomized requests.
module tb_sequenciador_banco;
    import sequenciador_banco_pkg::*;

    localparam int W = 32;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_escreve;
    logic [A-1:0] req_src_a, req_src_b, req_dest;
    logic         op_valid, op_ready;
    logic [W-1:0] op_a, op_b;
    logic         res_valid, res_ready;
    logic [W-1:0] res_dado;
    logic         rf_habilita;
    logic [A-1:0] rf_in_out_a, rf_out_b;
    logic [W-1:0] rf_e, rf_a, rf_b;
    logic         ocupado;

    always #5 clk = ~clk;

    sequenciador_banco dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_src_a(req_src_a), .i_req_src_b(req_src_b),
        .i_req_dest(req_dest), .i_req_escreve(req_escreve),
        .o_op_valid(op_valid), .i_op_ready(op_ready),
        .o_op_a(op_a), .o_op_b(op_b),
        .i_res_valid(res_valid), .o_res_ready(res_ready), .i_res_dado(res_dado),
        .o_rf_habilita(rf_habilita), .o_rf_in_out_a(rf_in_out_a),
        .o_rf_out_b(rf_out_b), .o_rf_e(rf_e),
        .i_rf_a(rf_a), .i_rf_b(rf_b),
        .o_ocupado(ocupado)
    );

    // ---------------- register bank (updates on falling edge, cleared by reset)
    logic [W-1:0] mem [8];
    logic [W-1:0] bank_a, bank_b;
    logic         pre_we;
    logic [A-1:0] pre_addr;
    logic [W-1:0] pre_dat;
    logic         corrupt;
    logic [W-1:0] junk;

    assign rf_a = corrupt ? junk : bank_a;
    assign rf_b = bank_b;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            bank_a <= '0;
            bank_b <= '0;
        end else begin
            if (rf_habilita) mem[rf_in_out_a] <= rf_e;
            if (pre_we) mem[pre_addr] <= pre_dat;
            bank_a <= mem[rf_in_out_a];
            bank_b <= mem[rf_out_b];
        end
    end

    // ---------------- reference model and scoreboard
    typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } ops_t;
    typedef struct packed { logic [A-1:0] addr; logic [W-1:0] dat; } wr_t;

    logic [W-1:0] ref_rf [8];
    ops_t exp_ops[$];
    wr_t  exp_wr[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: operands checked every cycle op_valid is high (stability), popped on transfer;
    // every write-enable cycle must match the next expected write-back.
    always @(negedge clk) begin
        if (!rst) begin
            if (op_valid) begin
                if (exp_ops.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_op_valid: got op_a %0h expected no operands", op_a);
                end else begin
                    check("op_a", op_a, exp_ops[0].a);
                    check("op_b", op_b, exp_ops[0].b);
                    if (op_ready) void'(exp_ops.pop_front());
                end
            end
            if (rf_habilita) begin
                if (exp_wr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_in_out_a, rf_e);
                end else begin
                    check("wr_addr", {29'd0, rf_in_out_a}, {29'd0, exp_wr[0].addr});
                    check("wr_data", rf_e, exp_wr[0].dat);
                    void'(exp_wr.pop_front());
                end
            end
        end
    end

    // ---------------- driver helpers (always entered/left at posedge+1)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [A-1:0] a, input logic [W-1:0] v);
        pre_addr = a; pre_dat = v; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
        ref_rf[a] = v;
    endtask

    task automatic accept(input logic [A-1:0] a, input logic [A-1:0] b,
                          input logic [A-1:0] d, input logic w);
        int n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_src_a = a; req_src_b = b; req_dest = d; req_escreve = w;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_src_a = A'($urandom); req_src_b = A'($urandom);
        req_dest  = A'($urandom); req_escreve = 1'($urandom);
    endtask

    task automatic issue(input logic [A-1:0] a, input logic [A-1:0] b, input logic [A-1:0] d,
                         input logic w, input logic [W-1:0] res, input int op_stall, input int res_stall);
        bit fast;
        int n;
        exp_ops.push_back(ops_t'{ref_rf[a], ref_rf[b]});
        if (w) begin
            exp_wr.push_back(wr_t'{d, res});
            ref_rf[d] = res;
        end
        fast = (op_stall == 0) && (res_stall == 0);
        op_ready  = fast;
        res_valid = fast && w;
        res_dado  = res;
        accept(a, b, d, w);
        check("ocupado_busy", {31'd0, ocupado}, 32'd1);
        if (fast) begin
            tick();
            check("op_valid_n1", {31'd0, op_valid}, 32'd1);
            tick();
            if (!w) begin
                check("req_ready_n2", {31'd0, req_ready}, 32'd1);
            end else begin
                check("res_ready_n2", {31'd0, res_ready}, 32'd1);
                tick();
                check("rf_habilita_n3", {31'd0, rf_habilita}, 32'd1);
                check("rf_e_n3", rf_e, res);
                tick();
                check("rf_habilita_n4", {31'd0, rf_habilita}, 32'd0);
                check("req_ready_n4", {31'd0, req_ready}, 32'd1);
            end
            op_ready = 1'b0;
            res_valid = 1'b0;
        end else begin
            n = 0;
            while (!op_valid && n < 10) begin tick(); n++; end
            check("op_valid_seen", {31'd0, op_valid}, 32'd1);
            for (int k = 0; k < op_stall; k++) begin
                corrupt = 1'b1;
                junk = $urandom;
                if (w) begin
                    res_valid = 1'($urandom_range(0, 1));
                    res_dado  = $urandom;
                end
                tick();
                check("no_write_operandos", {31'd0, rf_habilita}, 32'd0);
            end
            corrupt = 1'b0;
            res_valid = 1'b0;
            res_dado = res;
            op_ready = 1'b1;
            tick();
            op_ready = 1'b0;
            check("op_valid_dropped", {31'd0, op_valid}, 32'd0);
            if (w) begin
                for (int k = 0; k < res_stall; k++) begin
                    check("res_ready_wait", {31'd0, res_ready}, 32'd1);
                    check("no_write_resultado", {31'd0, rf_habilita}, 32'd0);
                    tick();
                end
                res_valid = 1'b1;
                tick();
                res_valid = 1'b0;
                check("rf_habilita_pulse", {31'd0, rf_habilita}, 32'd1);
                tick();
            end
            check("req_ready_end", {31'd0, req_ready}, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_op_valid"}, {31'd0, op_valid}, 32'd0);
        check({tag, "_rf_habilita"}, {31'd0, rf_habilita}, 32'd0);
        check({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
        check({tag, "_res_ready"}, {31'd0, res_ready}, 32'd0);
    endtask

    // ---------------- main stimulus
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_src_a = '0; req_src_b = '0; req_dest = '0; req_escreve = 1'b0;
        op_ready = 1'b0; res_valid = 1'b0; res_dado = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0; corrupt = 1'b0; junk = '0;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;

        #1;
        check_reset_outputs("rst0");
        check("rst0_op_a", op_a, 32'd0);
        check("rst0_op_b", op_b, 32'd0);
        check("rst0_rf_e", rf_e, 32'd0);
        check("rst0_addr_a", {29'd0, rf_in_out_a}, 32'd0);
        check("rst0_addr_b", {29'd0, rf_out_b}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic read, write-back, and read-after-write
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        issue(3'd1, 3'd2, 3'd0, 1'b0, 32'd0, 0, 0);
        issue(3'd1, 3'd2, 3'd3, 1'b1, 32'd12, 0, 0);
        issue(3'd3, 3'd3, 3'd0, 1'b0, 32'd0, 0, 0);

        // destination aliases a source
        preload(3'd4, 32'd9);
        issue(3'd4, 3'd1, 3'd4, 1'b1, 32'd20, 0, 0);
        issue(3'd4, 3'd2, 3'd0, 1'b0, 32'd0, 0, 0);

        // operand back-pressure with early res_valid and a moving bank output
        issue(3'd1, 3'd2, 3'd5, 1'b1, 32'd77, 6, 2);
        issue(3'd5, 3'd4, 3'd0, 1'b0, 32'd0, 6, 0);

        // reset while waiting in RESULTADO
        exp_ops.push_back(ops_t'{ref_rf[2], ref_rf[3]});
        op_ready = 1'b1; res_valid = 1'b0;
        accept(3'd2, 3'd3, 3'd6, 1'b1);
        tick();
        tick();
        op_ready = 1'b0;
        check("pre_rst_res_ready", {31'd0, res_ready}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_resultado");
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        req_src_a = 3'd1; req_src_b = 3'd1; req_dest = 3'd1; req_escreve = 1'b1;
        req_valid = 1'b1;
        tick();
        check("rst_no_accept", {31'd0, ocupado}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // reset in the middle of the write-back cycle
        preload(3'd2, 32'd31);
        preload(3'd3, 32'd41);
        exp_ops.push_back(ops_t'{ref_rf[2], ref_rf[3]});
        op_ready = 1'b1; res_valid = 1'b1; res_dado = 32'd55;
        accept(3'd2, 3'd3, 3'd6, 1'b1);
        tick();
        tick();
        tick();
        check("pre_rst_escrita", {31'd0, rf_habilita}, 32'd1);
        rst = 1'b1;
        #1 check_reset_outputs("rst_escrita");
        op_ready = 1'b0; res_valid = 1'b0;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        issue(3'd6, 3'd2, 3'd0, 1'b0, 32'd0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 8; i++) preload(A'(i), $urandom);
        for (int t = 0; t < 40; t++) begin
            int os, rs;
            os = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            issue(A'($urandom), A'($urandom), A'($urandom), 1'($urandom), $urandom, os, rs);
        end

        tick();
        tick();
        check("ops_queue_drained", exp_ops.size(), 32'd0);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
